fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the 16-bit pipelined processor, directly upstream of the hazard unit's control outputs. It owns the PC register, issues word requests to instruction memory with a valid/wait handshake, and loads the IF/ID pipeline register. It consumes `pcstall`, `IF_IDstall`, `flushIF_ID`, `PCSrc` and `jump`, and produces `fetch_stop`, which is OR'd into the hazard unit's `stop` input while an instruction-memory access is outstanding.

## Interface
- `ADDR_WIDTH`, 16, PC / instruction-memory word-address width
- `INSTR_WIDTH`, 16, instruction width
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `pcstall`  in  1  hold PC (from hazard unit)
- `IF_IDstall`  in  1  hold IF/ID register
- `flushIF_ID`  in  1  load bubble into IF/ID
- `PCSrc`  in  1  taken branch, redirect to `branch_target`
- `branch_target`  in  ADDR_WIDTH  branch destination
- `jump`  in  1  jump, redirect to `jump_target`
- `jump_target`  in  ADDR_WIDTH  jump destination
- `imem_req`  out  1  instruction-memory request
- `imem_addr`  out  ADDR_WIDTH  request word address
- `imem_rdata`  in  INSTR_WIDTH  returned instruction
- `imem_valid`  in  1  `imem_rdata` valid; completes the request
- `instrD`  out  INSTR_WIDTH  IF/ID instruction
- `pcplus1D`  out  ADDR_WIDTH  IF/ID PC+1
- `validD`  out  1  IF/ID holds a real instruction
- `fetch_stop`  out  1  fetch waiting on memory

## Operation
- FSM states: FETCH, DRAIN.
- Reset values: state=FETCH, pc=RESET_PC, instrD=0, pcplus1D=0, validD=0. While `rst` is asserted, `imem_req`=0 and `fetch_stop`=0.
- `imem_req`=1 in both states when not in reset. `imem_addr`=pc in FETCH and `pend_addr` in DRAIN. Both are held stable until `imem_valid`.
- `fetch_stop` = `imem_req` & !`imem_valid`, combinational. Zero-wait memory (valid in the same cycle as the request) never raises it.
- Next-PC priority, evaluated every cycle:
  1. `PCSrc` → `branch_target`
  2. `jump` → `jump_target`
  3. `imem_valid` & !`pcstall` → pc+1 (mod 2^ADDR_WIDTH; 0xFFFF wraps to 0x0000)
  4. otherwise hold.
- Redirect in FETCH with `imem_valid`=1: pc ← target, and the instruction is still offered to IF/ID (`flushIF_ID` from the hazard unit kills it).
- Redirect in FETCH with `imem_valid`=0: the request is outstanding and cannot be withdrawn.
  - `pend_addr` ← current pc, pc ← target, go to DRAIN.
  - DRAIN keeps requesting `pend_addr` until `imem_valid`, discards that data (no IF/ID load), then returns to FETCH.
- Redirect while in DRAIN: pc ← new target, remain in DRAIN. The latest redirect wins.
- IF/ID update, first matching rule applies:
  1. `flushIF_ID` → instrD=0, validD=0, pcplus1D=0.
  2. `IF_IDstall` → hold.
  3. FETCH & `imem_valid` → instrD=`imem_rdata`, pcplus1D=pc+1, validD=1.
  4. otherwise bubble (validD=0, instrD=0).
- `flushIF_ID` overrides `IF_IDstall`.
- `pcstall` does not block the IF/ID load.

## Timing
- Fetch latency: the instruction at address A, with valid in the request cycle, appears on instrD after one clock edge.
- Throughput: one instruction per cycle with zero-wait memory.
- N wait cycles produce N cycles of `fetch_stop`=1, and the IF/ID load occurs on the edge where `imem_valid`=1.
- Redirect to the first fetch of the target: 1 cycle if no request is outstanding; otherwise the remaining wait cycles + 1.
- `rst` asserted mid-wait: the outstanding response is ignored, and the FSM/PC restart at RESET_PC on the first cycle after `rst` deasserts.
- `PCSrc` and `jump` in the same cycle: the branch wins.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds output `perf_stall_cnt` (16-bit) and output `perf_redirect_cnt` (16-bit).
  - `perf_stall_cnt` increments on each cycle `fetch_stop`=1.
  - `perf_redirect_cnt` increments on each cycle `PCSrc`|`jump`=1.
  - Both saturate at 0xFFFF and reset to 0.
- Undefined: neither port nor the counters exist. Behaviour is otherwise identical.

## Test plan
- Reset, `imem_valid` tied 1, rdata=addr+0x100 → instrD sequence 0x0100, 0x0101, 0x0102 on consecutive cycles; validD=1 from the first edge after reset release.
- `imem_valid` low for 3 cycles at addr 0x0004 → `fetch_stop`=1 for exactly 3 cycles, `imem_addr` stable at 0x0004, then instrD loads 0x0104.
- `PCSrc`=1, `branch_target`=0x0040 while the request to 0x0005 is waiting 2 cycles → DRAIN; 0x0005 data discarded with no IF/ID load; next request addr=0x0040.
- `PCSrc` and `jump` together, targets 0x0010 / 0x0020 → next `imem_addr`=0x0010.
- `pcstall`=1 for 2 cycles with `IF_IDstall`=0 → PC held; `flushIF_ID`+`IF_IDstall` together → instrD=0, validD=0.
- PC=0xFFFF with valid → next `imem_addr`=0x0000. With `FETCH_PERF_CNT_EN` defined, in the 3-wait-cycle scenario, `perf_stall_cnt` increments by 3.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 16-bit pipelined processor.
// Owns the PC and issues word requests to instruction memory using a valid/wait handshake.
// Loads the IF/ID pipeline register.
// A redirect that arrives while a request is outstanding parks the FSM in DRAIN.
// DRAIN waits for the response and discards it before fetching resumes.
//
// Optional feature: define FETCH_PERF_CNT_EN to add saturating stall and
// redirect performance counters (perf_stall_cnt, perf_redirect_cnt).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pcstall             hold PC
//   IF_IDstall          hold IF/ID register
//   flushIF_ID          load bubble into IF/ID (overrides IF_IDstall)
//   PCSrc/branch_target taken branch redirect (wins over jump)
//   jump/jump_target    jump redirect
//   imem_req/imem_addr  instruction-memory request (combinational)
//   imem_rdata/imem_valid returned instruction, completes request
//   instrD/pcplus1D/validD IF/ID pipeline register
//   fetch_stop          request outstanding and not yet answered (combinational)
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pcstall,
  input  logic                   IF_IDstall,
  input  logic                   flushIF_ID,
  input  logic                   PCSrc,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  input  logic                   jump,
  input  logic [ADDR_WIDTH-1:0]  jump_target,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_valid,
  output logic [INSTR_WIDTH-1:0] instrD,
  output logic [ADDR_WIDTH-1:0]  pcplus1D,
  output logic                   validD,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]            perf_stall_cnt,
  output logic [15:0]            perf_redirect_cnt,
`endif
  output logic                   fetch_stop
);

  typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  pend_addr_q, pend_addr_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  pcplus1_q, pcplus1_d;
  logic                   valid_q, valid_d;

  logic                   redirect;
  logic [ADDR_WIDTH-1:0]  target;
  logic [ADDR_WIDTH-1:0]  pc_inc;

  assign redirect = PCSrc | jump;
  assign target   = PCSrc ? branch_target : jump_target;
  assign pc_inc   = pc_q + ADDR_WIDTH'(1);

  // Memory request side: held on pc (FETCH) or the abandoned address (DRAIN)
  assign imem_req   = ~rst;
  assign imem_addr  = (state_q == DRAIN) ? pend_addr_q : pc_q;
  assign fetch_stop = imem_req & ~imem_valid;

  // Next-state, next-PC and IF/ID update
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_addr_d = pend_addr_q;
    instr_d     = instr_q;
    pcplus1_d   = pcplus1_q;
    valid_d     = valid_q;

    // A DRAIN response belongs to the discarded address, so it never advances pc.
    if (redirect) begin
      pc_d = target;
    end else if (state_q == FETCH && imem_valid && !pcstall) begin
      pc_d = pc_inc;
    end

    unique case (state_q)
      FETCH: begin
        if (redirect && !imem_valid) begin
          pend_addr_d = pc_q;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_valid) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    if (flushIF_ID) begin
      instr_d   = '0;
      pcplus1_d = '0;
      valid_d   = 1'b0;
    end else if (IF_IDstall) begin
      instr_d   = instr_q;
    end else if (state_q == FETCH && imem_valid) begin
      instr_d   = imem_rdata;
      pcplus1_d = pc_inc;
      valid_d   = 1'b1;
    end else begin
      instr_d   = '0;
      valid_d   = 1'b0;
    end
  end

  // State, PC and IF/ID registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      pend_addr_q <= '0;
      instr_q     <= '0;
      pcplus1_q   <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_addr_q <= pend_addr_d;
      instr_q     <= instr_d;
      pcplus1_q   <= pcplus1_d;
      valid_q     <= valid_d;
    end
  end

  assign instrD   = instr_q;
  assign pcplus1D = pcplus1_q;
  assign validD   = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q, redirect_cnt_q;

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (fetch_stop && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (redirect && redirect_cnt_q != 16'hFFFF) begin
        redirect_cnt_q <= redirect_cnt_q + 16'd1;
      end
    end
  end

  assign perf_stall_cnt    = stall_cnt_q;
  assign perf_redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// The memory model returns addr+0x100; the bench drives imem_valid.
// Inputs change and outputs are sampled on the falling edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcstall, IF_IDstall, flushIF_ID, PCSrc, jump;
  logic [15:0] branch_target, jump_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] instrD, pcplus1D;
  logic        validD, fetch_stop;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_stall_cnt, perf_redirect_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr + 16'h0100;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .pcstall       (pcstall),
    .IF_IDstall    (IF_IDstall),
    .flushIF_ID    (flushIF_ID),
    .PCSrc         (PCSrc),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .instrD        (instrD),
    .pcplus1D      (pcplus1D),
    .validD        (validD),
`ifdef FETCH_PERF_CNT_EN
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_redirect_cnt (perf_redirect_cnt),
`endif
    .fetch_stop    (fetch_stop)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; pcstall = 0; IF_IDstall = 0; flushIF_ID = 0; PCSrc = 0; jump = 0;
    branch_target = '0; jump_target = '0; imem_valid = 1'b1;
    step(); step();
    #1;
    check("rst_req", 32'(imem_req), 0);
    check("rst_stop", 32'(fetch_stop), 0);
    check("rst_validD", 32'(validD), 0);
    check("rst_instrD", 32'(instrD), 0);
    check("rst_pcplus1D", 32'(pcplus1D), 0);

    // Zero-wait streaming from RESET_PC
    rst = 1'b0;
    #1;
    check("first_addr", 32'(imem_addr), 0);
    check("first_req", 32'(imem_req), 1);
    check("zw_stop", 32'(fetch_stop), 0);
    step();
    check("s0_instr", 32'(instrD), 32'h0100);
    check("s0_valid", 32'(validD), 1);
    check("s0_pc1", 32'(pcplus1D), 1);
    step();
    check("s1_instr", 32'(instrD), 32'h0101);
    step();
    check("s2_instr", 32'(instrD), 32'h0102);
    step();
    check("s3_instr", 32'(instrD), 32'h0103);
    check("wait_addr0", 32'(imem_addr), 4);

    // Three wait cycles at 0x0004
    for (int i = 0; i < 3; i++) begin
      imem_valid = 1'b0;
      #1;
      check("wait_stop", 32'(fetch_stop), 1);
      check("wait_addr", 32'(imem_addr), 4);
      step();
      if (i == 0) check("wait_bubble", 32'(validD), 0);
    end
    imem_valid = 1'b1;
    #1;
    check("wait_done_stop", 32'(fetch_stop), 0);
    check("wait_done_addr", 32'(imem_addr), 4);
    step();
    check("wait_instr", 32'(instrD), 32'h0104);
    check("wait_validD", 32'(validD), 1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_stall3", 32'(perf_stall_cnt), 3);
`endif

    // Branch while request to 0x0005 waits two cycles
    imem_valid = 1'b0; PCSrc = 1'b1; branch_target = 16'h0040;
    #1;
    check("br_addr", 32'(imem_addr), 5);
    step();
    PCSrc = 1'b0;
    #1;
    check("drain_addr", 32'(imem_addr), 5);
    check("drain_stop", 32'(fetch_stop), 1);
    check("drain_bubble", 32'(validD), 0);
    step();
    imem_valid = 1'b1;
    #1;
    check("drain_resp_addr", 32'(imem_addr), 5);
    step();
    check("drain_discard_v", 32'(validD), 0);
    check("drain_discard_i", 32'(instrD), 0);
    check("br_target_addr", 32'(imem_addr), 32'h0040);
    step();
    check("br_instr", 32'(instrD), 32'h0140);

    // Branch and jump together: branch wins
    PCSrc = 1'b1; jump = 1'b1; branch_target = 16'h0010; jump_target = 16'h0020;
    step();
    PCSrc = 1'b0; jump = 1'b0;
    check("prio_addr", 32'(imem_addr), 32'h0010);
    check("prio_instr", 32'(instrD), 32'h0141);
`ifdef FETCH_PERF_CNT_EN
    check("perf_redir2", 32'(perf_redirect_cnt), 2);
`endif

    // pcstall holds PC but IF/ID still loads
    pcstall = 1'b1;
    step();
    check("pcst_addr1", 32'(imem_addr), 32'h0010);
    check("pcst_instr1", 32'(instrD), 32'h0110);
    check("pcst_pc1D", 32'(pcplus1D), 32'h0011);
    step();
    check("pcst_addr2", 32'(imem_addr), 32'h0010);
    pcstall = 1'b0;
    step();
    check("pcst_release", 32'(imem_addr), 32'h0011);

    // flush overrides stall; then stall alone holds
    flushIF_ID = 1'b1; IF_IDstall = 1'b1;
    step();
    flushIF_ID = 1'b0; IF_IDstall = 1'b0;
    check("flush_instr", 32'(instrD), 0);
    check("flush_valid", 32'(validD), 0);
    check("flush_pc1D", 32'(pcplus1D), 0);
    step();
    check("post_flush", 32'(instrD), 32'h0112);
    IF_IDstall = 1'b1;
    step();
    IF_IDstall = 1'b0;
    check("stall_hold", 32'(instrD), 32'h0112);
    check("stall_pc_adv", 32'(imem_addr), 32'h0014);

    // PC wrap at 0xFFFF
    jump = 1'b1; jump_target = 16'hFFFF;
    step();
    jump = 1'b0;
    check("wrap_pre", 32'(imem_addr), 32'hFFFF);
    step();
    check("wrap_addr", 32'(imem_addr), 0);
    check("wrap_instr", 32'(instrD), 32'h00FF);
    check("wrap_pc1D", 32'(pcplus1D), 0);

    // Reset mid-wait restarts at RESET_PC
    jump = 1'b1; jump_target = 16'h0030;
    step();
    jump = 1'b0; imem_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("rstw_req", 32'(imem_req), 0);
    check("rstw_stop", 32'(fetch_stop), 0);
    step();
    rst = 1'b0;
    #1;
    check("rstw_addr", 32'(imem_addr), 0);
    check("rstw_valid", 32'(validD), 0);
    imem_valid = 1'b1;
    step();
    check("rstw_instr", 32'(instrD), 32'h0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
